// File: rtl/vec_pkg.sv
// Types and constants shared by the execute lanes and the vector-store sequencer.
package vec_pkg;

  localparam int LANES = 6;
  localparam int WIDTH = 8;

  typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } store_state_t;

endpackage

// File: rtl/vector_store_seq.sv
// Serialises a captured lane vector into byte-wide data-memory writes, stalling
// the pipeline until every lane has been offered to memory.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// WRITE | presenting lane idx to memory; waits on mem_ready for enabled lanes
// DONE  | one-cycle completion pulse, then back to IDLE
module vector_store_seq
  import vec_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  lane_vec_t         vector,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LANES-1:0]  lane_mask,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  store_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  lane_vec_t         vec_q;
  logic [ADDR_W-1:0] base_q;
  logic [LANES-1:0]  mask_q;
  logic              capture;
  logic              lane_adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        vec_q  <= vector;
        base_q <= base_addr;
        mask_q <= lane_mask;
      end
    end
  end

  // A masked-off lane still costs one cycle; an enabled lane waits for memory.
  assign lane_adv = ~mask_q[idx_q] | mem_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = (lane_mask != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        mem_we    = mask_q[idx_q];
        mem_addr  = base_q + ADDR_W'(idx_q);
        mem_wdata = vec_q[idx_q];
        if (lane_adv) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy;

endmodule

// File: tb/tb_vector_store_seq.sv
// Directed bench for vector_store_seq: table of whole store sequences plus
// hand-written backpressure, reset and ignored-start sequences.
module tb_vector_store_seq;
  import vec_pkg::*;

  logic              clk;
  logic              reset_n;
  logic              start;
  lane_vec_t         vector;
  logic [15:0]       base_addr;
  logic [LANES-1:0]  lane_mask;
  logic              mem_ready;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              busy;
  logic              stall;
  logic              done;

  int total = 0;
  int bad = 0;

  vector_store_seq #(.ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vector(vector),
    .base_addr(base_addr), .lane_mask(lane_mask), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    lane_vec_t         vec;
    logic [15:0]       base;
    logic [5:0]        mask;
    logic [5:0][15:0]  exp_addr;
    logic [5:0][7:0]   exp_data;
    logic [5:0]        exp_we;
    int                exp_done;
  } case_t;

  case_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic launch(input lane_vec_t v, input logic [15:0] b, input logic [5:0] m);
    vector    = v;
    base_addr = b;
    lane_mask = m;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_case(input int k);
    launch(tbl[k].vec, tbl[k].base, tbl[k].mask);
    for (int c = 1; c <= tbl[k].exp_done + 1; c++) begin
      @(negedge clk);
      if (c < tbl[k].exp_done) begin
        chk($sformatf("c%0d_we%0d", k, c), 32'(mem_we), 32'(tbl[k].exp_we[c-1]));
        chk($sformatf("c%0d_addr%0d", k, c), 32'(mem_addr), 32'(tbl[k].exp_addr[c-1]));
        chk($sformatf("c%0d_data%0d", k, c), 32'(mem_wdata), 32'(tbl[k].exp_data[c-1]));
        chk($sformatf("c%0d_done_early%0d", k, c), 32'(done), 32'd0);
      end else if (c == tbl[k].exp_done) begin
        chk($sformatf("c%0d_done", k), 32'(done), 32'd1);
        chk($sformatf("c%0d_done_we", k), 32'(mem_we), 32'd0);
        chk($sformatf("c%0d_done_busy", k), 32'(busy), 32'd1);
      end else begin
        chk($sformatf("c%0d_idle_busy", k), 32'(busy), 32'd0);
        chk($sformatf("c%0d_idle_done", k), 32'(done), 32'd0);
        chk($sformatf("c%0d_idle_addr", k), 32'(mem_addr), 32'd0);
      end
    end
  endtask

  logic [15:0] bp_addr [9];
  lane_vec_t   full_vec;
  int          ndone;

  initial begin
    full_vec = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    tbl[0] = '{full_vec, 16'h0100, 6'b111111,
               {16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100},
               {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 6'b111111, 7};
    tbl[1] = '{{8'hF5, 8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0}, 16'h0020, 6'b100101,
               {16'h0025, 16'h0024, 16'h0023, 16'h0022, 16'h0021, 16'h0020},
               {8'hF5, 8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0}, 6'b100101, 7};
    tbl[2] = '{{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 16'h0040, 6'b000000,
               '0, '0, 6'b000000, 1};
    tbl[3] = '{{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 16'hFFFE, 6'b111111,
               {16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE},
               {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 6'b111111, 7};
    bp_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0102, 16'h0102,
                16'h0102, 16'h0103, 16'h0104, 16'h0105};

    reset_n = 1'b0; start = 1'b0; vector = '0; base_addr = '0;
    lane_mask = '0; mem_ready = 1'b1;
    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    for (int k = 0; k < 4; k++) run_case(k);

    // backpressure: memory refuses lane 2 for three cycles
    launch(full_vec, 16'h0100, 6'b111111);
    for (int c = 1; c <= 11; c++) begin
      mem_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c <= 9) begin
        chk($sformatf("bp_we%0d", c), 32'(mem_we), 32'd1);
        chk($sformatf("bp_addr%0d", c), 32'(mem_addr), 32'(bp_addr[c-1]));
        chk($sformatf("bp_done_early%0d", c), 32'(done), 32'd0);
      end else if (c == 10) begin
        chk("bp_done", 32'(done), 32'd1);
      end else begin
        chk("bp_idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);

    // reset during lane 3 abandons the sequence
    launch(full_vec, 16'h0100, 6'b111111);
    repeat (4) @(negedge clk);
    chk("mr_lane3_addr", 32'(mem_addr), 32'h0103);
    reset_n = 1'b0;
    #1;
    chk("mr_we", 32'(mem_we), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_stall", 32'(stall), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || mem_we) ndone++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || mem_we) ndone++;
    end
    chk("mr_quiet", 32'(ndone), 32'd0);
    run_case(0);

    // start pulsed mid-sequence with different operands must be ignored
    launch(full_vec, 16'h0100, 6'b111111);
    vector = {8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    base_addr = 16'h0900;
    lane_mask = 6'b000001;
    start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) start = 1'b0;
      if (done) ndone++;
      if (c >= 3 && c <= 6) begin
        chk($sformatf("ig_addr%0d", c), 32'(mem_addr), 32'(16'h0100 + 16'(c - 1)));
        chk($sformatf("ig_data%0d", c), 32'(mem_wdata), 32'(8'(10 * c)));
      end
    end
    chk("ig_ndone", 32'(ndone), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_store_seq.md
Name: vector_store_seq

Overview:
Downstream consumer of the 6-lane execute result. On a vector-store instruction it captures the lane vector, base address and lane mask in one cycle. It then serialises the lanes as one byte-wide data-memory write per cycle. It stalls the pipeline until the sequence completes, and sits between the execute stage and the byte-wide data memory.

Parameters:
WIDTH, 8, bits per lane and per memory word
LANES, 6, number of vector lanes
ADDR_W, 16, data-memory address width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  vector-store request; sampled only in IDLE
vector  input  LANES x WIDTH  lane results from execute; lane 0 = [0]
base_addr  input  ADDR_W  address for lane 0
lane_mask  input  LANES  bit i=1 means lane i is written
mem_ready  input  1  memory accepts the current write this cycle
mem_we  output  1  write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  WIDTH  write data
busy  output  1  high in every state except IDLE
stall  output  1  equals busy; holds the upstream pipeline
done  output  1  one-cycle pulse when the sequence ends

Behaviour:
- Reset (async, reset_n=0): state=IDLE, lane index=0, captured vector/base/mask=0. All outputs are 0 immediately, independent of clk. A reset during WRITE abandons the sequence; no further writes occur.
- States:
  - IDLE: if start=1, capture vector/base_addr/lane_mask and set idx=0. Go to WRITE if lane_mask!=0, otherwise go to DONE with no writes.
  - WRITE: drive mem_addr=base+idx (mod 2^ADDR_W, wrap allowed), mem_wdata=captured lane[idx], mem_we=mask[idx].
    - The lane advances when (mask[idx]=0) or (mem_ready=1). A masked-off lane still consumes one cycle.
    - If mask[idx]=1 and mem_ready=0, hold idx and keep all mem_* outputs stable.
    - Advance from idx=LANES-1 goes to DONE; otherwise idx+1.
  - DONE: done=1 and mem_we=0 for exactly one cycle, then IDLE.
- Timing, full mask, mem_ready=1, start sampled on edge 0: lane i written in cycle i+1; done in cycle 7; busy low in cycle 8. The next start is accepted in cycle 8.
- start while not in IDLE is ignored. Upstream must hold its instruction while stall=1.
- Captured operands are frozen for the whole sequence; changes on vector/base_addr during busy have no effect.
- mem_we, mem_addr and mem_wdata are decoded from registered state only, with no combinational path from start. mem_addr and mem_wdata are 0 in IDLE.
- Address arithmetic is ADDR_W bits unsigned; the carry is discarded.

Decomposition:
- Shared package vec_pkg: LANES and WIDTH constants, the lane vector typedef (LANES x WIDTH packed array), and the store-FSM state enum (IDLE, WRITE, DONE). The execute lanes and this block share the lane typedef.
- No sub-module. The FSM, index counter and capture registers stay in one module.

Test Plan:
- Full write: start with vector={60,50,40,30,20,10} (lane5..0), base=0x0100, mask=6'b111111, mem_ready=1. Expect writes 0x0100←10 … 0x0105←60 in cycles 1-6, done in cycle 7, busy=0 in cycle 8.
- Sparse mask: mask=6'b100101, base=0x0020. Expect writes only at 0x0020, 0x0022, 0x0025; still 6 WRITE cycles; done in cycle 7.
- Backpressure: mem_ready=0 for 3 cycles at lane 2. Expect mem_addr=base+2 and mem_we=1 held for 3 cycles; done delayed by 3 cycles (cycle 10).
- Zero mask plus wrap: mask=0 gives done in cycle 1 with no mem_we. Then base=0xFFFE with full mask gives addresses FFFE, FFFF, 0000, 0001, 0002, 0003.
- Reset mid-sequence: assert reset_n=0 during lane 3. Expect mem_we/busy/stall=0 immediately and no done. After release, a new start behaves as in the full-write case.
- Ignored start: pulse start with a different vector during WRITE. The captured data is unchanged and exactly one done is produced.
